// File: rtl/hamming_serial_tx_if.sv
// Handshake and line-side signal bundle for the Hamming(7,4) serial transmitter.
//   in_valid / in_ready : nibble handshake (producer drives valid, transmitter drives ready)
//   in_data [0:3]       : data nibble d[0..3]
//   err_en / err_pos    : optional single-bit error injection, sampled with the nibble
//   code_out [0:6]      : codeword latched at acceptance (including any injected error)
//   tx                  : serial line, idles high
//   busy / done         : frame in progress / one-cycle end-of-frame pulse
// Modports: master = nibble producer, slave = transmitter.
interface hamming_serial_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [0:3] in_data;
    logic       err_en;
    logic [2:0] err_pos;
    logic [0:6] code_out;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, in_data, err_en, err_pos,
        input  in_ready, code_out, tx, busy, done
    );

    modport slave (
        input  in_valid, in_data, err_en, err_pos,
        output in_ready, code_out, tx, busy, done
    );
endinterface

// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) encoder and framed serial transmitter.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any frame in progress
//   bus   : hamming_serial_tx_if.slave (nibble handshake, error injection, codeword, tx line,
//           busy, done)
// Frame: start bit (0), code bits h0..h6, stop bit (1); CLKS_PER_BIT cycles per bit.
// Codeword: h0=d0 h1=d1 h2=d2 h3=d0^d1^d2 h4=d3 h5=d0^d1^d3 h6=d0^d2^d3.
module hamming_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hamming_serial_tx_if.slave        bus
);
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        idx_q, idx_d;
    logic [0:6]        code_q, code_d;
    logic              done_q, done_d;
    logic [0:6]        code_enc;
    logic              bit_end;

    // Encoder with optional single-bit flip; err_pos == 7 means no flip.
    always_comb begin
        code_enc = {bus.in_data[0],
                    bus.in_data[1],
                    bus.in_data[2],
                    bus.in_data[0] ^ bus.in_data[1] ^ bus.in_data[2],
                    bus.in_data[3],
                    bus.in_data[0] ^ bus.in_data[1] ^ bus.in_data[3],
                    bus.in_data[0] ^ bus.in_data[2] ^ bus.in_data[3]};
        if (bus.err_en && (bus.err_pos != 3'd7)) begin
            code_enc[bus.err_pos] = ~code_enc[bus.err_pos];
        end
    end

    assign bit_end = (timer_q == TimerLast);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        code_d  = code_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    code_d  = code_enc;
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (idx_q == 3'd6) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    timer_d = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    // Line and status outputs decode registered state only.
    always_comb begin
        bus.tx = 1'b1;
        unique case (state_q)
            StStart: bus.tx = 1'b0;
            StData:  bus.tx = code_q[idx_q];
            default: bus.tx = 1'b1;
        endcase
    end

    assign bus.in_ready = (state_q == StIdle);
    assign bus.busy     = (state_q != StIdle);
    assign bus.code_out = code_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_hamming_serial_tx.sv
// Scoreboard bench for hamming_serial_tx (CLKS_PER_BIT = 4).
module tb_hamming_serial_tx;
    localparam int unsigned Cpb = 4;

    typedef struct {
        logic [0:6] code;
        bit         clean;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    bit          mon_act = 1'b0;
    int unsigned acc_cyc = 0;

    hamming_serial_tx_if bus();

    hamming_serial_tx #(.CLKS_PER_BIT(Cpb)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a nibble, wait (bounded) for acceptance, and queue the expected codeword.
    task automatic send(input logic [0:3] d, input logic e, input logic [2:0] p,
                        input logic [0:6] exp, input bit clean, input bit hold);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.err_en   = e;
        bus.err_pos  = p;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{code: exp, clean: clean});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) begin
            // Garbage while busy must be ignored.
            bus.in_valid = 1'b0;
            bus.in_data  = ~d;
            bus.err_en   = 1'b1;
            bus.err_pos  = 3'd0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || mon_act) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || mon_act) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    // Monitor: follows every frame the DUT emits and compares against the queue.
    initial begin
        exp_t       cur;
        int         mon_cnt = 0;
        logic [0:6] c;
        logic       want;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_act = 1'b0;
            end else begin
                if (!mon_act && bus.busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'(1), 32'(0));
                    end else begin
                        cur     = exp_q.pop_front();
                        mon_act = 1'b1;
                        mon_cnt = 0;
                        chk("code_out", 32'(bus.code_out), 32'(cur.code));
                        if (cur.clean) begin
                            c = bus.code_out;
                            chk("syndrome", 32'({c[0] ^ c[2] ^ c[4] ^ c[6],
                                                 c[0] ^ c[1] ^ c[4] ^ c[5],
                                                 c[0] ^ c[1] ^ c[2] ^ c[3]}), 32'(0));
                        end
                    end
                end else if (!mon_act && !bus.busy) begin
                    if (!$isunknown(bus.done) && bus.done) chk("done_stray", 32'(1), 32'(0));
                end
                if (mon_act) begin
                    if (mon_cnt < 36) begin
                        if (mon_cnt < 4) want = 1'b0;
                        else if (mon_cnt < 32) want = cur.code[(mon_cnt - 4) / 4];
                        else want = 1'b1;
                        chk("tx_bit", 32'(bus.tx), 32'(want));
                        chk("busy_in_frame", 32'(bus.busy), 32'(1));
                        chk("ready_in_frame", 32'(bus.in_ready), 32'(0));
                        chk("done_early", 32'(bus.done), 32'(0));
                        mon_cnt++;
                    end else begin
                        chk("done_pulse", 32'(bus.done), 32'(1));
                        chk("idle_tx", 32'(bus.tx), 32'(1));
                        chk("idle_ready", 32'(bus.in_ready), 32'(1));
                        chk("idle_busy", 32'(bus.busy), 32'(0));
                        chk("code_hold", 32'(bus.code_out), 32'(cur.code));
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [0:6] tbl [16];
        logic [0:3] d;
        int unsigned a1;
        tbl = '{7'b0000000, 7'b0000111, 7'b0011001, 7'b0011110,
                7'b0101010, 7'b0101101, 7'b0110011, 7'b0110100,
                7'b1001011, 7'b1001100, 7'b1010010, 7'b1010101,
                7'b1100001, 7'b1100110, 7'b1111000, 7'b1111111};
        bus.in_valid = 1'b0;
        bus.in_data  = 4'b0000;
        bus.err_en   = 1'b0;
        bus.err_pos  = 3'd7;

        // Reset state, held and after release with no input.
        #12;
        chk("rst_tx", 32'(bus.tx), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_tx_rst", 32'(bus.tx), 32'(1));
            chk("idle_ready_rst", 32'(bus.in_ready), 32'(1));
            chk("idle_busy_rst", 32'(bus.busy), 32'(0));
            chk("idle_done_rst", 32'(bus.done), 32'(0));
            chk("idle_code_rst", 32'(bus.code_out), 32'(0));
        end

        // Directed encodings.
        send(4'b1011, 1'b0, 3'd7, 7'b1010101, 1'b1, 1'b0);
        send(4'b0000, 1'b0, 3'd7, 7'b0000000, 1'b1, 1'b0);
        send(4'b1111, 1'b0, 3'd7, 7'b1111111, 1'b1, 1'b0);
        send(4'b1000, 1'b0, 3'd7, 7'b1001011, 1'b1, 1'b0);
        wait_idle();

        // Exhaustive nibble sweep.
        for (int i = 0; i < 16; i++) begin
            d = 4'(i);
            send(d, 1'b0, 3'd7, tbl[i], 1'b1, 1'b0);
        end
        wait_idle();

        // Error injection.
        send(4'b1011, 1'b1, 3'd2, 7'b1000101, 1'b0, 1'b0);
        send(4'b1011, 1'b1, 3'd7, 7'b1010101, 1'b1, 1'b0);
        send(4'b0000, 1'b1, 3'd6, 7'b0000001, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held; data changes while the first frame runs.
        send(4'b0001, 1'b0, 3'd7, 7'b0000111, 1'b1, 1'b1);
        a1 = acc_cyc;
        send(4'b1000, 1'b0, 3'd7, 7'b1001011, 1'b1, 1'b0);
        chk("b2b_gap", 32'(acc_cyc - a1), 32'(37));
        wait_idle();

        // Reset during DATA bit 3 aborts at once.
        send(4'b1011, 1'b0, 3'd7, 7'b1010101, 1'b1, 1'b0);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(bus.tx), 32'(1));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_ready", 32'(bus.in_ready), 32'(1));
        chk("abort_done", 32'(bus.done), 32'(0));
        chk("abort_code", 32'(bus.code_out), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(4'b0110, 1'b0, 3'd7, 7'b0110011, 1'b1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
